lowmc_key_axil_responder: RTL and testbench

// - AXI4-Lite slave (responder) holding the LowMC key: the end a PS/VIP master writes key words into and reads back from.
// - Hands the assembled KEY_WIDTH-bit key to the LowMC core over a valid/ready port and tracks completion.
// - Sits between the AXI interconnect and the LowMC key-schedule core inside the coprocessor IP.

---
 rtl/lowmc_axil_pkg.sv | 35 +++
 rtl/lowmc_key_axil_responder_if.sv | 34 +++
 rtl/lowmc_key_axil_responder_handoff_fsm.sv | 42 ++++
 rtl/lowmc_key_axil_responder.sv | 142 ++++++++++++++
 tb/tb_lowmc_key_axil_responder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lowmc_axil_pkg.sv
// Shared constants and types for the LowMC key AXI4-Lite responder.
package lowmc_axil_pkg;

  localparam logic [4:0] OFF_KEY0    = 5'h00;
  localparam logic [4:0] OFF_KEY1    = 5'h04;
  localparam logic [4:0] OFF_KEY2    = 5'h08;
  localparam logic [4:0] OFF_KEY3    = 5'h0C;
  localparam logic [4:0] OFF_CTRL    = 5'h10;
  localparam logic [4:0] OFF_STATUS  = 5'h14;
  localparam logic [4:0] OFF_KEY_CNT = 5'h18;
  localparam logic [4:0] OFF_ID      = 5'h1C;

  localparam logic [2:0] WIDX_CTRL    = 3'd4;
  localparam logic [2:0] WIDX_STATUS  = 3'd5;
  localparam logic [2:0] WIDX_KEY_CNT = 3'd6;
  localparam logic [2:0] WIDX_ID      = 3'd7;

  localparam logic [31:0] ID_VALUE = 32'h4C4B4559;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, OFFER, WAIT_DONE} key_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/lowmc_key_axil_responder_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the key responder (slave).
interface lowmc_key_axil_responder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID, S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID, S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID, S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID, S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/lowmc_key_axil_responder_handoff_fsm.sv
// Key hand-off sequencer: offers the key to the core, then waits for the schedule to finish.
module lowmc_key_handoff_fsm
  import lowmc_axil_pkg::*;
(
  input  logic gclk,
  input  logic grst_n,
  input  logic start_i,
  input  logic key_ready_i,
  input  logic done_i,
  output logic busy_o,
  output logic key_valid_o,
  output logic cnt_inc_o,
  output logic done_set_o,
  output logic err_set_o
);

  key_state_t state_q, state_d;

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) state_q <= IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_i)     state_d = OFFER;
      OFFER:     if (key_ready_i) state_d = WAIT_DONE;
      WAIT_DONE: if (done_i)      state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Outputs decode the state register directly so key_valid_o falls with reset.
  always_comb begin
    busy_o      = (state_q != IDLE);
    key_valid_o = (state_q == OFFER);
    cnt_inc_o   = (state_q == OFFER) && key_ready_i;
    done_set_o  = (state_q == WAIT_DONE) && done_i;
    err_set_o   = start_i && (state_q != IDLE);
  end

endmodule

// File: rtl/lowmc_key_axil_responder.sv
// AXI4-Lite register block holding the LowMC key and handing it to the key-schedule core.
module lowmc_key_axil_responder
  import lowmc_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int KEY_WIDTH          = 128
)(
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  lowmc_key_axil_responder_if.slave  axi,
  output logic [KEY_WIDTH-1:0]       key_o,
  output logic                       key_valid_o,
  input  logic                       key_ready_i,
  input  logic                       done_i
);

  localparam int         KEY_WORDS = KEY_WIDTH / 32;
  localparam logic [3:0] KEY_MASK  = 4'((1 << KEY_WORDS) - 1);

  logic clk, rst_n;
  assign clk   = S_AXI_ACLK;
  assign rst_n = S_AXI_ARESETN;

  logic                          aw_held, w_held, bvalid_q, awready_q, wready_q;
  logic                          arready_q, rvalid_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q, rdata_q, rd_data;
  logic [3:0]                    w_strb_q;
  logic [1:0]                    bresp_q, wr_resp;
  logic [3:0][31:0]              key_q;
  logic                          done_q, err_q;
  logic [31:0]                   key_cnt_q;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, do_write;
  logic aw_held_d, w_held_d, bvalid_d, rvalid_d;
  logic key_wr_ok, ctrl_wr, key_we, start, clr;
  logic busy, cnt_inc, done_set, err_set;
  logic [2:0] aw_idx, ar_idx;

  assign aw_hs    = axi.S_AXI_AWVALID & awready_q;
  assign w_hs     = axi.S_AXI_WVALID  & wready_q;
  assign b_hs     = bvalid_q & axi.S_AXI_BREADY;
  assign ar_hs    = axi.S_AXI_ARVALID & arready_q;
  assign r_hs     = rvalid_q & axi.S_AXI_RREADY;
  assign do_write = aw_held & w_held & ~bvalid_q;

  // Holding registers stay occupied until the B handshake: one write in flight at most.
  assign aw_held_d = ~b_hs & (aw_held | aw_hs);
  assign w_held_d  = ~b_hs & (w_held | w_hs);
  assign bvalid_d  = do_write | (bvalid_q & ~b_hs);
  assign rvalid_d  = ar_hs | (rvalid_q & ~r_hs);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aw_held <= 1'b0; w_held <= 1'b0; bvalid_q <= 1'b0; rvalid_q <= 1'b0;
      awready_q <= 1'b0; wready_q <= 1'b0; arready_q <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
      bresp_q <= RESP_OKAY; rdata_q <= '0;
    end else begin
      aw_held   <= aw_held_d;
      w_held    <= w_held_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      awready_q <= ~aw_held_d & ~bvalid_d;
      wready_q  <= ~w_held_d & ~bvalid_d;
      arready_q <= ~rvalid_d;
      if (aw_hs)    aw_addr_q <= axi.S_AXI_AWADDR;
      if (w_hs)     begin w_data_q <= axi.S_AXI_WDATA; w_strb_q <= axi.S_AXI_WSTRB; end
      if (do_write) bresp_q <= wr_resp;
      if (ar_hs)    rdata_q <= rd_data;
    end

  assign aw_idx = aw_addr_q[4:2];
  assign ar_idx = axi.S_AXI_ARADDR[4:2];

  always_comb begin
    key_wr_ok = 1'b0;
    ctrl_wr   = 1'b0;
    wr_resp   = RESP_OKAY;
    if (!aw_idx[2]) begin
      if (busy || !KEY_MASK[aw_idx[1:0]]) wr_resp = RESP_SLVERR;
      else                                key_wr_ok = 1'b1;
    end else if (aw_idx == WIDX_CTRL) ctrl_wr = 1'b1;
    else                              wr_resp = RESP_SLVERR;
  end

  assign key_we = do_write & key_wr_ok;
  assign start  = do_write & ctrl_wr & w_strb_q[0] & w_data_q[0];
  assign clr    = do_write & ctrl_wr & w_strb_q[0] & w_data_q[1];

  // Reads sample the registers before this cycle's write lands.
  always_comb begin
    rd_data = '0;
    case (ar_idx)
      WIDX_CTRL:    rd_data = '0;
      WIDX_STATUS:  rd_data = {29'd0, err_q, done_q, busy};
      WIDX_KEY_CNT: rd_data = key_cnt_q;
      WIDX_ID:      rd_data = ID_VALUE;
      default:      rd_data = key_q[ar_idx[1:0]];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      key_cnt_q <= '0;
    end else begin
      if (key_we)  key_q[aw_idx[1:0]] <= apply_strb(key_q[aw_idx[1:0]], w_data_q, w_strb_q);
      if (cnt_inc) key_cnt_q <= key_cnt_q + 32'd1;
      done_q <= done_set | (done_q & ~clr);
      err_q  <= err_set  | (err_q  & ~clr);
    end

  lowmc_key_handoff_fsm u_fsm (
    .gclk        (clk),
    .grst_n      (rst_n),
    .start_i     (start),
    .key_ready_i (key_ready_i),
    .done_i      (done_i),
    .busy_o      (busy),
    .key_valid_o (key_valid_o),
    .cnt_inc_o   (cnt_inc),
    .done_set_o  (done_set),
    .err_set_o   (err_set)
  );

  assign key_o             = key_q[KEY_WORDS-1:0];
  assign axi.S_AXI_AWREADY = awready_q;
  assign axi.S_AXI_WREADY  = wready_q;
  assign axi.S_AXI_BVALID  = bvalid_q;
  assign axi.S_AXI_BRESP   = bresp_q;
  assign axi.S_AXI_ARREADY = arready_q;
  assign axi.S_AXI_RVALID  = rvalid_q;
  assign axi.S_AXI_RDATA   = rdata_q;
  assign axi.S_AXI_RRESP   = RESP_OKAY;

  logic unused_bits;
  assign unused_bits = ^{aw_addr_q[1:0], axi.S_AXI_ARADDR[1:0], axi.S_AXI_AWPROT, axi.S_AXI_ARPROT};

endmodule

// File: tb/tb_lowmc_key_axil_responder.sv
// Directed bench for the LowMC key responder: register table plus hand-written timing sequences.
module tb_lowmc_key_axil_responder;
  import lowmc_axil_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  lowmc_key_axil_responder_if axi();
  logic [127:0] key;
  logic key_valid, key_ready = 1'b0, done = 1'b0;

  lowmc_key_axil_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .KEY_WIDTH(128)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .axi(axi.slave),
    .key_o(key), .key_valid_o(key_valid), .key_ready_i(key_ready), .done_i(done));

  int total = 0, passed = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    total++;
    $display("FAIL %s: handshake timeout", nm);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n = 0;
    bit aw_hit, w_hit;
    axi.S_AXI_AWADDR = a; axi.S_AXI_WDATA = d; axi.S_AXI_WSTRB = s;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    while ((axi.S_AXI_AWVALID || axi.S_AXI_WVALID) && n < 50) begin
      aw_hit = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_hit  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(negedge clk);
      if (aw_hit) axi.S_AXI_AWVALID = 1'b0;
      if (w_hit)  axi.S_AXI_WVALID  = 1'b0;
      n++;
    end
    axi.S_AXI_BREADY = 1'b1;
    while (!axi.S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
    resp = axi.S_AXI_BRESP;
    if (n >= 50) begin
      timeout("write");
      axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; resp = 2'bxx;
    end
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    axi.S_AXI_ARADDR = a; axi.S_AXI_ARVALID = 1'b1;
    while (!axi.S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b1;
    while (!axi.S_AXI_RVALID && n < 50) begin @(negedge clk); n++; end
    d = axi.S_AXI_RDATA; resp = axi.S_AXI_RRESP;
    if (n >= 50) begin timeout("read"); d = 'x; end
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    bit stable;

    tbl[0]  = '{1'b1, OFF_KEY0,    32'h1,        4'hF, RESP_OKAY,   32'h0,        "wr_key0"};
    tbl[1]  = '{1'b1, OFF_KEY1,    32'h2,        4'hF, RESP_OKAY,   32'h0,        "wr_key1"};
    tbl[2]  = '{1'b1, OFF_KEY2,    32'h3,        4'hF, RESP_OKAY,   32'h0,        "wr_key2"};
    tbl[3]  = '{1'b1, OFF_KEY3,    32'h4,        4'hF, RESP_OKAY,   32'h0,        "wr_key3"};
    tbl[4]  = '{1'b0, OFF_KEY0,    32'h0,        4'h0, RESP_OKAY,   32'h1,        "rd_key0"};
    tbl[5]  = '{1'b0, OFF_KEY1,    32'h0,        4'h0, RESP_OKAY,   32'h2,        "rd_key1"};
    tbl[6]  = '{1'b0, OFF_KEY2,    32'h0,        4'h0, RESP_OKAY,   32'h3,        "rd_key2"};
    tbl[7]  = '{1'b0, OFF_KEY3,    32'h0,        4'h0, RESP_OKAY,   32'h4,        "rd_key3"};
    tbl[8]  = '{1'b1, OFF_KEY0,    32'h11111111, 4'hF, RESP_OKAY,   32'h0,        "wr_key0_ones"};
    tbl[9]  = '{1'b1, OFF_KEY0,    32'hAABBCCDD, 4'h2, RESP_OKAY,   32'h0,        "wr_key0_strb"};
    tbl[10] = '{1'b0, OFF_KEY0,    32'h0,        4'h0, RESP_OKAY,   32'h1111CC11, "rd_key0_strb"};
    tbl[11] = '{1'b1, OFF_KEY0,    32'h1,        4'hF, RESP_OKAY,   32'h0,        "wr_key0_restore"};
    tbl[12] = '{1'b0, OFF_ID,      32'h0,        4'h0, RESP_OKAY,   32'h4C4B4559, "rd_id"};
    tbl[13] = '{1'b0, OFF_KEY_CNT, 32'h0,        4'h0, RESP_OKAY,   32'h0,        "rd_keycnt0"};
    tbl[14] = '{1'b0, OFF_STATUS,  32'h0,        4'h0, RESP_OKAY,   32'h0,        "rd_status0"};
    tbl[15] = '{1'b0, OFF_CTRL,    32'h0,        4'h0, RESP_OKAY,   32'h0,        "rd_ctrl"};
    tbl[16] = '{1'b1, OFF_KEY_CNT, 32'h5,        4'hF, RESP_SLVERR, 32'h0,        "wr_keycnt_ro"};
    tbl[17] = '{1'b1, 5'h03,       32'h1,        4'hF, RESP_OKAY,   32'h0,        "wr_unaligned"};
    tbl[18] = '{1'b0, 5'h02,       32'h0,        4'h0, RESP_OKAY,   32'h1,        "rd_unaligned"};

    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0; axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0;
    axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_RREADY = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_awready", axi.S_AXI_AWREADY, 0);
    check("rst_bvalid",  axi.S_AXI_BVALID, 0);
    check("rst_rvalid",  axi.S_AXI_RVALID, 0);
    check("rst_rdata",   axi.S_AXI_RDATA, 0);
    check("rst_key",     key, 0);
    check("rst_keyvld",  key_valid, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
        check(tbl[i].name, r, tbl[i].resp);
      end else begin
        axi_read(tbl[i].addr, d, r);
        check({tbl[i].name, "_resp"}, r, tbl[i].resp);
        check(tbl[i].name, d, tbl[i].rdata);
      end
    end

    // W three cycles ahead of AW, then BREADY held off
    axi.S_AXI_WDATA = 32'h2; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_WVALID = 1'b0;
    check("sep_wready_held", axi.S_AXI_WREADY, 0);
    repeat (2) @(negedge clk);
    check("sep_bvalid_no_aw", axi.S_AXI_BVALID, 0);
    check("sep_awready", axi.S_AXI_AWREADY, 1);
    axi.S_AXI_AWADDR = OFF_KEY1; axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    check("sep_bvalid_aw_cycle", axi.S_AXI_BVALID, 0);
    @(negedge clk);
    check("sep_bvalid_rise", axi.S_AXI_BVALID, 1);
    check("sep_bresp", axi.S_AXI_BRESP, RESP_OKAY);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(axi.S_AXI_BVALID === 1'b1 && axi.S_AXI_BRESP === RESP_OKAY)) stable = 1'b0;
    end
    check("sep_b_stable", stable, 1);
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
    check("sep_b_cleared", axi.S_AXI_BVALID, 0);

    // START with the core stalled, stray done in OFFER, then accept and finish
    axi_write(OFF_CTRL, 32'h1, 4'hF, r);
    check("start_resp", r, RESP_OKAY);
    stable = 1'b1;
    repeat (4) begin
      if (!(key_valid === 1'b1 && key === {32'd4, 32'd3, 32'd2, 32'd1})) stable = 1'b0;
      @(negedge clk);
    end
    check("offer_stable", stable, 1);
    done = 1'b1; @(negedge clk); done = 1'b0;
    axi_read(OFF_STATUS, d, r);
    check("status_done_ignored", d, 32'h1);
    key_ready = 1'b1; @(negedge clk); key_ready = 1'b0;
    check("keyvld_after_accept", key_valid, 0);
    axi_read(OFF_KEY_CNT, d, r);
    check("keycnt_1", d, 32'h1);
    axi_read(OFF_STATUS, d, r);
    check("status_wait", d, 32'h1);
    done = 1'b1; @(negedge clk); done = 1'b0;
    axi_read(OFF_STATUS, d, r);
    check("status_done", d, 32'h2);
    axi_write(OFF_CTRL, 32'h2, 4'hF, r);
    axi_read(OFF_STATUS, d, r);
    check("status_clr", d, 32'h0);

    // busy-time protections
    axi_write(OFF_CTRL, 32'h1, 4'hF, r);
    axi_write(OFF_KEY0, 32'hDEAD, 4'hF, r);
    check("busy_key_slverr", r, RESP_SLVERR);
    axi_read(OFF_KEY0, d, r);
    check("busy_key_kept", d, 32'h1);
    axi_write(OFF_CTRL, 32'h1, 4'hF, r);
    check("busy_start_okay", r, RESP_OKAY);
    axi_read(OFF_STATUS, d, r);
    check("busy_start_err", d, 32'h5);
    axi_write(OFF_CTRL, 32'h3, 4'hF, r);
    axi_read(OFF_STATUS, d, r);
    check("clr_start_set_wins", d, 32'h5);
    axi_write(OFF_STATUS, 32'h0, 4'hF, r);
    check("status_wr_slverr", r, RESP_SLVERR);
    axi_read(OFF_ID, d, r);
    check("busy_rd_id", d, ID_VALUE);

    // reset while OFFER with a read response pending
    axi.S_AXI_ARADDR = OFF_ID; axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    check("pre_rst_rvalid", axi.S_AXI_RVALID, 1);
    check("pre_rst_keyvld", key_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_keyvld", key_valid, 0);
    check("rst_mid_rvalid", axi.S_AXI_RVALID, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(OFF_KEY0, d, r);
    check("post_rst_key0", d, 32'h0);
    axi_read(OFF_STATUS, d, r);
    check("post_rst_status", d, 32'h0);

    // read and write of KEY0 landing on the same edge
    axi.S_AXI_AWADDR = OFF_KEY0; axi.S_AXI_WDATA = 32'h77; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_ARADDR = OFF_KEY0; axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    check("rw_same_rvalid", axi.S_AXI_RVALID, 1);
    check("rw_same_old", axi.S_AXI_RDATA, 32'h0);
    check("rw_same_bvalid", axi.S_AXI_BVALID, 1);
    axi.S_AXI_RREADY = 1'b1; axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0; axi.S_AXI_BREADY = 1'b0;
    axi_read(OFF_KEY0, d, r);
    check("rw_same_new", d, 32'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
